// File: rtl/ld_pkg.sv
// ld_pkg: shared types, curve constants and GF(2^4) helpers for LD scalar multiplication.
// Revision 1.0
`default_nettype none

package ld_pkg;

    localparam int FIELD_W = 4;
    localparam int POINT_W = 12;

    typedef logic [FIELD_W-1:0] fe_t;

    typedef struct packed {
        fe_t Z;
        fe_t Y;
        fe_t X;
    } point_t;

    localparam point_t INF_POINT = point_t'(12'h001);

    // Field poly x^4+x+1 (low bits); curve y^2+xy = x^3 + a*x^2 + b.
    localparam fe_t FIELD_POLY = 4'h3;
    localparam fe_t CURVE_A    = 4'h4;
    localparam fe_t CURVE_B    = 4'h1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_DBL  = 3'd2,
        S_ADD  = 3'd3,
        S_DONE = 3'd4
    } ldsm_state_t;

    function automatic fe_t gf_mul(input fe_t a, input fe_t b);
        fe_t acc;
        fe_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < FIELD_W; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[FIELD_W-2:0], 1'b0} ^ (sh[FIELD_W-1] ? FIELD_POLY : fe_t'(0));
        end
        return acc;
    endfunction

    function automatic fe_t gf_sq(input fe_t a);
        return gf_mul(a, a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/LDalu.sv
// LDalu: combinational LD point doubling (op=1, A) or mixed addition (op=0, A affine + B).
// Revision 1.0
`default_nettype none

module LDalu
    import ld_pkg::*;
(
    input  logic   op,
    input  point_t A,
    input  point_t B,
    output point_t R
);

    fe_t d_x2, d_z2, d_z3, d_bz4, d_x3, d_y3;

    assign d_x2  = gf_sq(A.X);
    assign d_z2  = gf_sq(A.Z);
    assign d_z3  = gf_mul(d_x2, d_z2);
    assign d_bz4 = gf_mul(CURVE_B, gf_sq(d_z2));
    assign d_x3  = gf_sq(d_x2) ^ d_bz4;
    assign d_y3  = gf_mul(d_bz4, d_z3)
                 ^ gf_mul(d_x3, gf_mul(CURVE_A, d_z3) ^ gf_sq(A.Y) ^ d_bz4);

    // A is treated as affine (A.Z assumed 1), so only B carries a Z coordinate here.
    fe_t a_zz, a_a, a_b, a_c, a_d, a_z3, a_e, a_x3, a_f, a_g, a_y3;

    assign a_zz = gf_sq(B.Z);
    assign a_a  = gf_mul(A.Y, a_zz) ^ B.Y;
    assign a_b  = gf_mul(A.X, B.Z) ^ B.X;
    assign a_c  = gf_mul(B.Z, a_b);
    assign a_d  = gf_mul(gf_sq(a_b), a_c ^ gf_mul(CURVE_A, a_zz));
    assign a_z3 = gf_sq(a_c);
    assign a_e  = gf_mul(a_a, a_c);
    assign a_x3 = gf_sq(a_a) ^ a_d ^ a_e;
    assign a_f  = a_x3 ^ gf_mul(A.X, a_z3);
    assign a_g  = gf_mul(A.X ^ A.Y, gf_sq(a_z3));
    assign a_y3 = gf_mul(a_e ^ a_z3, a_f) ^ a_g;

    assign R = op ? {d_z3, d_y3, d_x3} : {a_z3, a_y3, a_x3};

endmodule

`default_nettype wire

// File: rtl/ld_scalar_mult.sv
// ld_scalar_mult: left-to-right double-and-add k*P on LD points, one ALU op per cycle.
// Revision 1.0
`default_nettype none

module ld_scalar_mult #(
    parameter int K_W     = 4,
    parameter int POINT_W = 12
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [K_W-1:0]     k,
    input  logic [POINT_W-1:0] P,
    output logic [POINT_W-1:0] R,
    output logic               busy,
    output logic               done
);

    import ld_pkg::*;

    localparam int             CNT_W    = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ldsm_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [K_W-1:0]   kr_q, kr_d;
    point_t           pr_q, pr_d;
    point_t           q_q, q_d;
    point_t           r_q, r_d;

    logic   alu_op;
    point_t alu_a, alu_b, alu_r;

    LDalu u_alu (
        .op (alu_op),
        .A  (alu_a),
        .B  (alu_b),
        .R  (alu_r)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kr_d    = kr_q;
        pr_d    = pr_q;
        q_d     = q_q;
        r_d     = r_q;
        alu_op  = 1'b0;
        alu_a   = pr_q;
        alu_b   = q_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kr_d    = k;
                    pr_d    = point_t'(P);
                    cnt_d   = CNT_LAST;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!kr_q[cnt_q]) begin
                    if (cnt_q == '0) begin
                        q_d     = INF_POINT;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    q_d = pr_q;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                        state_d = S_DBL;
                    end
                end
            end
            S_DBL: begin
                alu_op = 1'b1;
                alu_a  = q_q;
                alu_b  = '0;
                q_d    = alu_r;
                // The add for a set bit reuses the same cnt, so no decrement here.
                if (kr_q[cnt_q]) begin
                    state_d = S_ADD;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_ADD: begin
                alu_op = 1'b0;
                alu_a  = pr_q;
                alu_b  = q_q;
                q_d    = alu_r;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = S_DBL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            r_d = q_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_LAST;
            kr_q    <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kr_q    <= kr_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign R    = r_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ld_scalar_mult.sv
// tb_ld_scalar_mult: directed self-checking bench for ld_scalar_mult.
// Revision 1.0
`default_nettype none

module tb_ld_scalar_mult;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [3:0]  k;
    logic [11:0] P;
    logic [11:0] R;
    logic        busy;
    logic        done;

    int n_checks;
    int n_errors;

    ld_scalar_mult #(
        .K_W     (4),
        .POINT_W (12)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .start (start),
        .k     (k),
        .P     (P),
        .R     (R),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input logic [3:0] kk, input logic [11:0] pp, input logic chk_r,
                          input logic [11:0] exp_r, input int exp_lat, input string tag);
        int          lat;
        int          busy_cyc;
        logic [11:0] r_at_done;
        lat       = 0;
        busy_cyc  = 0;
        r_at_done = '0;
        @(negedge clk);
        start = 1'b1;
        k     = kk;
        P     = pp;
        @(posedge clk);
        #1;
        start = 1'b0;
        k     = ~kk;
        P     = ~pp;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat       = c;
                r_at_done = R;
                break;
            end
            if (busy) busy_cyc++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
        if (chk_r) chk({tag, "_R"}, {20'd0, r_at_done}, {20'd0, exp_r});
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        if (chk_r) chk({tag, "_R_held"}, {20'd0, R}, {20'd0, exp_r});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          dcount;
        int          first;
        int          d1;
        int          d2;
        logic [11:0] rf;

        n_checks = 0;
        n_errors = 0;
        n_rst    = 1'b0;
        start    = 1'b0;
        k        = '0;
        P        = '0;
        rf       = '0;

        repeat (2) @(negedge clk);
        chk("rst_R", {20'd0, R}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        run_op(4'd1,  12'h138, 1'b1, 12'h138, 5, "k1");
        run_op(4'd2,  12'h138, 1'b1, 12'hC2E, 5, "k2");
        run_op(4'd3,  12'h138, 1'b1, 12'h227, 6, "k3");
        run_op(4'd0,  12'h5A3, 1'b1, 12'h001, 5, "k0");
        run_op(4'd5,  12'h138, 1'b0, 12'h000, 6, "k5");
        run_op(4'd8,  12'h138, 1'b0, 12'h000, 5, "k8");
        run_op(4'd15, 12'h138, 1'b0, 12'h000, 8, "k15");

        // Re-pulse start with a different k while the first operation sits in DBL.
        @(negedge clk);
        start = 1'b1;
        k     = 4'd3;
        P     = 12'h138;
        @(posedge clk);
        #1;
        start  = 1'b0;
        dcount = 0;
        first  = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (first == 0) begin
                    first = c;
                    rf    = R;
                end
            end
            if (c == 4) begin
                start = 1'b1;
                k     = 4'd1;
            end else if (c == 5) begin
                start = 1'b0;
            end
        end
        chk("busy_start_latency", first, 6);
        chk("busy_start_R", {20'd0, rf}, 32'h227);
        chk("busy_start_done_count", dcount, 1);

        // Reset in the ADD cycle of a k=3 run.
        @(negedge clk);
        start = 1'b1;
        k     = 4'd3;
        P     = 12'h138;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_R", {20'd0, R}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcount++;
        end
        n_rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("mid_rst_no_done", dcount, 0);
        run_op(4'd2, 12'h138, 1'b1, 12'hC2E, 5, "after_rst_k2");

        // start held high: the IDLE cycle after DONE accepts the next request.
        @(negedge clk);
        start = 1'b1;
        k     = 4'd1;
        P     = 12'h138;
        @(posedge clk);
        #1;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
        end
        start = 1'b0;
        chk("b2b_first_done", d1, 5);
        chk("b2b_second_done", d2, 11);
        repeat (12) @(negedge clk);
        chk("b2b_drained_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
